// File: rtl/fifo_unpack.sv
// Width-down unpacker: holds one wide source word and presents it as `ratio`
// narrow beats on a FIFO-style dequeue interface, refilling on the last beat.
module fifo_unpack #(
   parameter int unsigned width     = 8,
   parameter int unsigned ratio     = 4,
   parameter bit          msb_first = 1'b0,
   parameter bit          guarded   = 1'b1
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [width*ratio-1:0]   SRC_D,
   input  logic                     SRC_EMPTY_N,
   output logic                     SRC_DEQ,
   output logic [width-1:0]         D_OUT,
   output logic                     EMPTY_N,
   output logic                     LAST,
   input  logic                     DEQ,
   input  logic                     CLR
);

   localparam int unsigned WordW   = width * ratio;
   localparam int unsigned IdxW    = (ratio > 1) ? $clog2(ratio) : 1;
   localparam int unsigned LastIdx = ratio - 1;

   logic              valid_q, valid_d;
   logic [WordW-1:0]  word_q,  word_d;
   logic [IdxW-1:0]   idx_q,   idx_d;

   logic              take;
   logic              last_c;
   logic              src_deq_c;
   logic [IdxW-1:0]   slice;
   int unsigned       bit_off;

   // State register
   always_ff @(posedge CLK) begin
      if (RST) begin
         valid_q <= 1'b0;
         word_q  <= '0;
         idx_q   <= '0;
      end else begin
         valid_q <= valid_d;
         word_q  <= word_d;
         idx_q   <= idx_d;
      end
   end

   // Next state: clear beats load, load beats advance/empty
   always_comb begin
      valid_d = valid_q;
      word_d  = word_q;
      idx_d   = idx_q;
      if (CLR) begin
         valid_d = 1'b0;
         idx_d   = '0;
      end else if (src_deq_c) begin
         valid_d = 1'b1;
         word_d  = SRC_D;
         idx_d   = '0;
      end else if (take && !last_c) begin
         idx_d   = idx_q + IdxW'(1);
      end else if (take) begin
         valid_d = 1'b0;
         idx_d   = '0;
      end
   end

   // Outputs and source dequeue strobe
   always_comb begin
      take      = DEQ && valid_q;
      last_c    = valid_q && (idx_q == IdxW'(LastIdx));
      src_deq_c = !RST && !CLR && SRC_EMPTY_N && (!valid_q || (take && last_c));
      slice     = msb_first ? (IdxW'(LastIdx) - idx_q) : idx_q;
      bit_off   = 32'(slice) * width;
      D_OUT     = width'(word_q >> bit_off);
      EMPTY_N   = valid_q;
      LAST      = last_c;
      SRC_DEQ   = src_deq_c;
   end

   generate
      if (guarded) begin : g_checks
         always_ff @(posedge CLK) begin
            if (!RST && DEQ && !valid_q)
               $warning("Warning: fifo_unpack: %m -- Dequeuing from empty");
            if (!RST && src_deq_c && !SRC_EMPTY_N)
               $warning("Warning: fifo_unpack: %m -- Dequeuing from empty source");
         end
      end
   endgenerate

endmodule

// File: tb/tb_fifo_unpack.sv
// Directed bench for fifo_unpack: LSB-first and MSB-first instances, each
// scenario checks {EMPTY_N, LAST, SRC_DEQ, D_OUT} once per cycle.
module tb_fifo_unpack;

   logic        clk = 1'b0;
   logic        rst = 1'b1, clr = 1'b0, sen = 1'b0, deq = 1'b0;
   logic [31:0] src_d = '0;
   logic        src_deq, empty_n, last;
   logic [7:0]  d_out;

   logic        m_rst = 1'b1, m_clr = 1'b0, m_sen = 1'b0, m_deq = 1'b0;
   logic [31:0] m_src_d = '0;
   logic        m_src_deq, m_empty_n, m_last;
   logic [7:0]  m_d_out;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] W0 = 32'h44332211;
   localparam logic [31:0] W1 = 32'h88776655;

   always #5 clk = ~clk;

   fifo_unpack #(.width(8), .ratio(4), .msb_first(1'b0), .guarded(1'b1)) dut (
      .CLK(clk), .RST(rst), .SRC_D(src_d), .SRC_EMPTY_N(sen), .SRC_DEQ(src_deq),
      .D_OUT(d_out), .EMPTY_N(empty_n), .LAST(last), .DEQ(deq), .CLR(clr)
   );

   fifo_unpack #(.width(8), .ratio(4), .msb_first(1'b1), .guarded(1'b1)) dut_msb (
      .CLK(clk), .RST(m_rst), .SRC_D(m_src_d), .SRC_EMPTY_N(m_sen), .SRC_DEQ(m_src_deq),
      .D_OUT(m_d_out), .EMPTY_N(m_empty_n), .LAST(m_last), .DEQ(m_deq), .CLR(m_clr)
   );

   // Apply inputs at negedge, settle, then the caller samples before posedge
   task automatic drive(input logic r, input logic c, input logic s, input logic q,
                        input logic [31:0] d);
      @(negedge clk);
      rst = r; clr = c; sen = s; deq = q; src_d = d;
      #1;
   endtask

   task automatic mdrive(input logic r, input logic s, input logic q, input logic [31:0] d);
      @(negedge clk);
      m_rst = r; m_clr = 1'b0; m_sen = s; m_deq = q; m_src_d = d;
      #1;
   endtask

   task automatic test_reset;
      drive(1'b1, 1'b0, 1'b1, 1'b1, W0);
      checks++;
      if ({empty_n, last, src_deq, d_out} !== 11'b000_00000000) begin
         errors++;
         $display("FAIL reset_during got %b exp %b", {empty_n, last, src_deq, d_out}, 11'b0);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, W0);
      checks++;
      if ({empty_n, last, src_deq, d_out} !== 11'b000_00000000) begin
         errors++;
         $display("FAIL reset_after got %b exp %b", {empty_n, last, src_deq, d_out}, 11'b0);
      end
      mdrive(1'b0, 1'b0, 1'b0, W0);
      checks++;
      if ({m_empty_n, m_last, m_src_deq, m_d_out} !== 11'b000_00000000) begin
         errors++;
         $display("FAIL reset_msb got %b exp %b", {m_empty_n, m_last, m_src_deq, m_d_out}, 11'b0);
      end
   endtask

   task automatic test_single;
      logic [10:0] exp;
      drive(1'b0, 1'b0, 1'b1, 1'b0, W0);
      checks++;
      if ({empty_n, last, src_deq} !== 3'b001) begin
         errors++;
         $display("FAIL single_load got %b exp 001", {empty_n, last, src_deq});
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b1, W0);
         exp = {1'b1, 1'(i == 3), 1'b0, 8'(W0 >> (8 * i))};
         checks++;
         if ({empty_n, last, src_deq, d_out} !== exp) begin
            errors++;
            $display("FAIL single_beat%0d got %h exp %h", i, {empty_n, last, src_deq, d_out}, exp);
         end
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, W0);
      checks++;
      if ({empty_n, last, src_deq} !== 3'b000) begin
         errors++;
         $display("FAIL single_empty got %b exp 000", {empty_n, last, src_deq});
      end
   endtask

   task automatic test_back_to_back;
      logic [10:0] exp;
      logic [31:0] w;
      drive(1'b0, 1'b0, 1'b1, 1'b0, W0);
      checks++;
      if ({empty_n, last, src_deq} !== 3'b001) begin
         errors++;
         $display("FAIL b2b_load got %b exp 001", {empty_n, last, src_deq});
      end
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b0, 1'(i < 4), 1'b1, W1);
         w   = (i < 4) ? W0 : W1;
         exp = {1'b1, 1'(i % 4 == 3), 1'(i == 3), 8'(w >> (8 * (i % 4)))};
         checks++;
         if ({empty_n, last, src_deq, d_out} !== exp) begin
            errors++;
            $display("FAIL b2b_beat%0d got %h exp %h", i, {empty_n, last, src_deq, d_out}, exp);
         end
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, W1);
      checks++;
      if ({empty_n, last, src_deq} !== 3'b000) begin
         errors++;
         $display("FAIL b2b_empty got %b exp 000", {empty_n, last, src_deq});
      end
   endtask

   task automatic test_backpressure;
      logic [10:0] exp;
      drive(1'b0, 1'b0, 1'b1, 1'b0, W0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, W1);
      checks++;
      if ({empty_n, last, src_deq, d_out} !== {3'b100, 8'h11}) begin
         errors++;
         $display("FAIL bp_first got %h exp %h", {empty_n, last, src_deq, d_out}, {3'b100, 8'h11});
      end
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b0, W1);
         checks++;
         if ({empty_n, last, src_deq, d_out} !== {3'b100, 8'h22}) begin
            errors++;
            $display("FAIL bp_hold%0d got %h exp %h", i, {empty_n, last, src_deq, d_out}, {3'b100, 8'h22});
         end
      end
      for (int i = 1; i < 4; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b1, W1);
         exp = {1'b1, 1'(i == 3), 1'b0, 8'(W0 >> (8 * i))};
         checks++;
         if ({empty_n, last, src_deq, d_out} !== exp) begin
            errors++;
            $display("FAIL bp_resume%0d got %h exp %h", i, {empty_n, last, src_deq, d_out}, exp);
         end
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, W1);
      checks++;
      if ({empty_n, last, src_deq} !== 3'b000) begin
         errors++;
         $display("FAIL bp_empty got %b exp 000", {empty_n, last, src_deq});
      end
   endtask

   task automatic test_clear;
      logic [10:0] exp;
      drive(1'b0, 1'b0, 1'b1, 1'b0, W0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, W1);
      drive(1'b0, 1'b1, 1'b1, 1'b1, W1);
      checks++;
      if ({empty_n, last, src_deq, d_out} !== {3'b100, 8'h22}) begin
         errors++;
         $display("FAIL clr_cycle got %h exp %h", {empty_n, last, src_deq, d_out}, {3'b100, 8'h22});
      end
      drive(1'b0, 1'b0, 1'b1, 1'b0, W1);
      checks++;
      if ({empty_n, last, src_deq} !== 3'b001) begin
         errors++;
         $display("FAIL clr_after got %b exp 001", {empty_n, last, src_deq});
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, W1);
      checks++;
      if ({empty_n, last, src_deq, d_out} !== {3'b100, 8'h55}) begin
         errors++;
         $display("FAIL clr_reload got %h exp %h", {empty_n, last, src_deq, d_out}, {3'b100, 8'h55});
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b1, W1);
         exp = {1'b1, 1'(i == 3), 1'b0, 8'(W1 >> (8 * i))};
         checks++;
         if ({empty_n, last, src_deq, d_out} !== exp) begin
            errors++;
            $display("FAIL clr_drain%0d got %h exp %h", i, {empty_n, last, src_deq, d_out}, exp);
         end
      end
   endtask

   task automatic test_rst_mid;
      drive(1'b0, 1'b0, 1'b1, 1'b0, W0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, W1);
      drive(1'b0, 1'b0, 1'b0, 1'b1, W1);
      drive(1'b1, 1'b0, 1'b1, 1'b1, W1);
      checks++;
      if ({empty_n, last, src_deq, d_out} !== {3'b100, 8'h33}) begin
         errors++;
         $display("FAIL rst_mid_cycle got %h exp %h", {empty_n, last, src_deq, d_out}, {3'b100, 8'h33});
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, W1);
      checks++;
      if ({empty_n, last, src_deq, d_out} !== 11'b0) begin
         errors++;
         $display("FAIL rst_mid_after got %h exp %h", {empty_n, last, src_deq, d_out}, 11'b0);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1, W1);
      checks++;
      if ({empty_n, last, src_deq, d_out} !== 11'b0) begin
         errors++;
         $display("FAIL rst_mid_deq_empty got %h exp %h", {empty_n, last, src_deq, d_out}, 11'b0);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, W1);
      checks++;
      if ({empty_n, last, src_deq, d_out} !== 11'b0) begin
         errors++;
         $display("FAIL rst_mid_hold got %h exp %h", {empty_n, last, src_deq, d_out}, 11'b0);
      end
   endtask

   task automatic test_msb_first;
      logic [10:0] exp;
      mdrive(1'b0, 1'b1, 1'b0, W0);
      checks++;
      if ({m_empty_n, m_last, m_src_deq} !== 3'b001) begin
         errors++;
         $display("FAIL msb_load got %b exp 001", {m_empty_n, m_last, m_src_deq});
      end
      for (int i = 0; i < 4; i++) begin
         mdrive(1'b0, 1'b0, 1'b1, W1);
         exp = {1'b1, 1'(i == 3), 1'b0, 8'(W0 >> (8 * (3 - i)))};
         checks++;
         if ({m_empty_n, m_last, m_src_deq, m_d_out} !== exp) begin
            errors++;
            $display("FAIL msb_beat%0d got %h exp %h", i, {m_empty_n, m_last, m_src_deq, m_d_out}, exp);
         end
      end
      mdrive(1'b0, 1'b0, 1'b0, W1);
      checks++;
      if ({m_empty_n, m_last, m_src_deq} !== 3'b000) begin
         errors++;
         $display("FAIL msb_empty got %b exp 000", {m_empty_n, m_last, m_src_deq});
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_clear();
      test_rst_mid();
      test_msb_first();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
